// File: rtl/store_buffer_pkg.sv
// Shared constants for the store buffer: address/data widths, default depth and pointer width.
package store_buffer_pkg;

  localparam int unsigned ADDR_LEN = 32;
  localparam int unsigned DATA_LEN = 32;
  localparam int unsigned SB_DEPTH = 4;
  localparam int unsigned SB_PTR_W = $clog2(SB_DEPTH);

  function automatic int unsigned sb_ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store buffer bus: store capture, ROB commit, forwarding lookup and dmem drain port.
interface store_buffer_if #(
  parameter int unsigned ADDR_LEN = store_buffer_pkg::ADDR_LEN,
  parameter int unsigned DATA_LEN = store_buffer_pkg::DATA_LEN
);
  logic                st_we_i;
  logic [ADDR_LEN-1:0] st_addr_i;
  logic [DATA_LEN-1:0] st_data_i;
  logic [1:0]          com_store_num_i;
  logic                kill_i;
  logic                load_busy_i;
  logic [ADDR_LEN-1:0] ld_addr_i;
  logic                fwd_hit_o;
  logic [DATA_LEN-1:0] fwd_data_o;
  logic                full_o;
  logic                empty_o;
  logic                dmem_we_o;
  logic [ADDR_LEN-1:0] dmem_addr_o;
  logic [DATA_LEN-1:0] dmem_wdata_o;

  modport master (
    output st_we_i, st_addr_i, st_data_i, com_store_num_i, kill_i, load_busy_i, ld_addr_i,
    input  fwd_hit_o, fwd_data_o, full_o, empty_o, dmem_we_o, dmem_addr_o, dmem_wdata_o
  );

  modport slave (
    input  st_we_i, st_addr_i, st_data_i, com_store_num_i, kill_i, load_busy_i, ld_addr_i,
    output fwd_hit_o, fwd_data_o, full_o, empty_o, dmem_we_o, dmem_addr_o, dmem_wdata_o
  );
endinterface

// File: rtl/store_buffer_fwd_match.sv
// Priority search for the youngest valid entry whose word address matches the load address.
module store_buffer_fwd_match #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDR_LEN = 32,
  parameter int unsigned PTR_W    = 2
) (
  input  logic [PTR_W-1:0]    head,
  input  logic [PTR_W:0]      count,
  input  logic [ADDR_LEN-1:0] addr [DEPTH],
  input  logic [ADDR_LEN-1:0] ld_addr,
  output logic                hit,
  output logic [PTR_W-1:0]    idx
);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [ADDR_LEN-1:0] WORD_MASK = ~ADDR_LEN'(3);

  logic [PTR_W-1:0] slot;

  // Scan oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit  = 1'b0;
    idx  = head;
    slot = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (((addr[slot] ^ ld_addr) & WORD_MASK) == '0)) begin
        hit = 1'b1;
        idx = slot;
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// In-order speculative store buffer with commit, kill and one-per-cycle drain to dmem.
// Build option: STORE_BUFFER_FWD_EN selects data forwarding; otherwise fwd_hit_o flags a conflict.
module store_buffer #(
  parameter int unsigned DEPTH    = store_buffer_pkg::SB_DEPTH,
  parameter int unsigned ADDR_LEN = store_buffer_pkg::ADDR_LEN,
  parameter int unsigned DATA_LEN = store_buffer_pkg::DATA_LEN
) (
  input  logic           clk_i,
  input  logic           reset_i,
  store_buffer_if.slave  bus
);
  import store_buffer_pkg::*;

  localparam int unsigned PTR_W = sb_ptr_w(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [ADDR_LEN-1:0] WORD_MASK = ~ADDR_LEN'(3);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [ADDR_LEN-1:0] addr_q [DEPTH];
  logic [DATA_LEN-1:0] data_q [DEPTH];
  ptr_t head, tail;
  cnt_t count, com_count;
  cnt_t uncom, req, commit, com_next, count_next;
  logic full, empty, enq, drain;
  logic                dmem_we;
  logic [ADDR_LEN-1:0] dmem_addr;
  logic [DATA_LEN-1:0] dmem_wdata;

  always_comb begin
    full       = (count == CNT_W'(DEPTH));
    empty      = (count == '0);
    enq        = bus.st_we_i && !full && !bus.kill_i;
    drain      = (com_count != '0) && !bus.load_busy_i;
    uncom      = count - com_count;
    req        = CNT_W'(bus.com_store_num_i);
    commit     = (req > uncom) ? uncom : req;
    com_next   = com_count + commit - CNT_W'(drain);
    // Kill keeps only what is committed after this cycle's commit and drain.
    count_next = bus.kill_i ? com_next : count + CNT_W'(enq) - CNT_W'(drain);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      com_count  <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      assert (!(bus.st_we_i && full && !bus.kill_i))
        else $warning("store_buffer: store dropped while full");
      assert (req <= uncom)
        else $warning("store_buffer: commit request clamped");
      head      <= head + ptr_t'(drain);
      tail      <= bus.kill_i ? head + ptr_t'(drain) + ptr_t'(com_next) : tail + ptr_t'(enq);
      count     <= count_next;
      com_count <= com_next;
      dmem_we   <= drain;
      if (drain) begin
        dmem_addr  <= addr_q[head];
        dmem_wdata <= data_q[head];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      addr_q[tail] <= bus.st_addr_i;
      data_q[tail] <= bus.st_data_i;
    end
  end

  assign bus.full_o       = full;
  assign bus.empty_o      = empty;
  assign bus.dmem_we_o    = dmem_we;
  assign bus.dmem_addr_o  = dmem_addr;
  assign bus.dmem_wdata_o = dmem_wdata;

`ifdef STORE_BUFFER_FWD_EN
  logic fwd_hit;
  ptr_t fwd_idx;

  store_buffer_fwd_match #(
    .DEPTH    (DEPTH),
    .ADDR_LEN (ADDR_LEN),
    .PTR_W    (PTR_W)
  ) u_fwd_match (
    .head    (head),
    .count   (count),
    .addr    (addr_q),
    .ld_addr (bus.ld_addr_i),
    .hit     (fwd_hit),
    .idx     (fwd_idx)
  );

  assign bus.fwd_hit_o  = fwd_hit;
  assign bus.fwd_data_o = fwd_hit ? data_q[fwd_idx] : '0;
`else
  logic [DEPTH-1:0] slot_hit;
  ptr_t             off;

  always_comb begin
    slot_hit = '0;
    off      = '0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      off         = ptr_t'(j) - head;
      slot_hit[j] = ({1'b0, off} < count) && (((addr_q[j] ^ bus.ld_addr_i) & WORD_MASK) == '0);
    end
  end

  assign bus.fwd_hit_o  = |slot_hit;
  assign bus.fwd_data_o = '0;
`endif
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected drains are queued at stimulus time and checked by a monitor.
module tb_store_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } drain_t;

  drain_t exp_q[$];

  store_buffer_if #(.ADDR_LEN(32), .DATA_LEN(32)) sb ();

  store_buffer #(.DEPTH(4), .ADDR_LEN(32), .DATA_LEN(32)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (sb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    sb.st_we_i   = 1'b1;
    sb.st_addr_i = a;
    sb.st_data_i = d;
    tick();
    sb.st_we_i   = 1'b0;
  endtask

  task automatic expect_drain(input logic [31:0] a, input logic [31:0] d);
    drain_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: every dmem write strobe must match the oldest expected drain.
  always @(negedge clk) begin
    if (sb.dmem_we_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_drain: got addr 0x%0h data 0x%0h expected no write",
                 sb.dmem_addr_o, sb.dmem_wdata_o);
      end else begin
        drain_t e;
        e = exp_q.pop_front();
        check("drain_addr", sb.dmem_addr_o, e.addr);
        check("drain_data", sb.dmem_wdata_o, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    sb.st_we_i = 1'b0; sb.st_addr_i = '0; sb.st_data_i = '0;
    sb.com_store_num_i = '0; sb.kill_i = 1'b0; sb.load_busy_i = 1'b0; sb.ld_addr_i = '0;

    // Reset state
    #3;
    check("rst_full", sb.full_o, 0);
    check("rst_empty", sb.empty_o, 1);
    check("rst_fwd_hit", sb.fwd_hit_o, 0);
    check("rst_fwd_data", sb.fwd_data_o, 0);
    check("rst_dmem_we", sb.dmem_we_o, 0);
    check("rst_dmem_addr", sb.dmem_addr_o, 0);
    check("rst_dmem_wdata", sb.dmem_wdata_o, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Fill, overflow attempt, commit 2+2, drain
    for (int i = 0; i < 4; i++) store(32'h100 + 32'(4 * i), 32'(i + 1));
    check("fill_full", sb.full_o, 1);
    check("fill_empty", sb.empty_o, 0);
    store(32'h110, 32'h5);
    check("overflow_full", sb.full_o, 1);
    for (int i = 0; i < 4; i++) expect_drain(32'h100 + 32'(4 * i), 32'(i + 1));
    sb.com_store_num_i = 2'd2;
    idle(2);
    sb.com_store_num_i = 2'd0;
    idle(8);
    check("drain_all_empty", sb.empty_o, 1);
    check("drain_all_full", sb.full_o, 0);
    check("drain_all_q", 32'(exp_q.size()), 0);

    // Kill keeps committed entry, drops the rest and the kill-cycle store
    store(32'h300, 32'h31);
    store(32'h304, 32'h32);
    store(32'h308, 32'h33);
    expect_drain(32'h300, 32'h31);
    sb.com_store_num_i = 2'd1;
    tick();
    sb.com_store_num_i = 2'd0;
    sb.kill_i = 1'b1;
    sb.st_we_i = 1'b1; sb.st_addr_i = 32'h3F0; sb.st_data_i = 32'h3F;
    tick();
    sb.kill_i = 1'b0;
    sb.st_we_i = 1'b0;
    idle(4);
    check("kill_empty", sb.empty_o, 1);
    check("kill_q", 32'(exp_q.size()), 0);

    // Forwarding: youngest match wins; lower address bits ignored
    store(32'h200, 32'hAA);
    store(32'h200, 32'hBB);
    sb.ld_addr_i = 32'h200;
    #1;
    check("fwd_hit_200", sb.fwd_hit_o, 1);
`ifdef STORE_BUFFER_FWD_EN
    check("fwd_data_200", sb.fwd_data_o, 32'hBB);
`else
    check("fwd_data_200", sb.fwd_data_o, 32'h0);
`endif
    sb.ld_addr_i = 32'h202;
    #1;
    check("fwd_hit_202", sb.fwd_hit_o, 1);
    sb.ld_addr_i = 32'h204;
    #1;
    check("fwd_hit_204", sb.fwd_hit_o, 0);
    check("fwd_data_204", sb.fwd_data_o, 0);
    sb.ld_addr_i = 32'h200;
    sb.kill_i = 1'b1;
    tick();
    sb.kill_i = 1'b0;
    check("fwd_kill_empty", sb.empty_o, 1);
    check("fwd_after_kill", sb.fwd_hit_o, 0);
    sb.ld_addr_i = '0;

    // load_busy suppresses drain for 3 cycles
    store(32'h400, 32'h41);
    store(32'h404, 32'h42);
    expect_drain(32'h400, 32'h41);
    expect_drain(32'h404, 32'h42);
    sb.load_busy_i = 1'b1;
    sb.com_store_num_i = 2'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      sb.com_store_num_i = 2'd0;
      check("busy_no_we", sb.dmem_we_o, 0);
    end
    sb.load_busy_i = 1'b0;
    idle(5);
    check("busy_empty", sb.empty_o, 1);
    check("busy_q", 32'(exp_q.size()), 0);

    // Steady enqueue+commit+drain across pointer wrap
    for (int k = 0; k < 10; k++) begin
      expect_drain(32'h500 + 32'(4 * k), 32'h50 + 32'(k));
      sb.com_store_num_i = (k == 0) ? 2'd0 : 2'd1;
      store(32'h500 + 32'(4 * k), 32'h50 + 32'(k));
      if (k >= 2) check("wrap_steady_full_empty", {31'b0, sb.full_o} | {30'b0, sb.empty_o, 1'b0}, 0);
    end
    sb.com_store_num_i = 2'd1;
    tick();
    sb.com_store_num_i = 2'd0;
    idle(5);
    check("wrap_empty", sb.empty_o, 1);
    check("wrap_q", 32'(exp_q.size()), 0);

    // Asynchronous reset during a drain pulse
    store(32'h600, 32'h61);
    store(32'h604, 32'h62);
    expect_drain(32'h600, 32'h61);
    sb.com_store_num_i = 2'd2;
    tick();
    sb.com_store_num_i = 2'd0;
    for (int n = 0; n < 10 && sb.dmem_we_o !== 1'b1; n++) @(negedge clk);
    check("rst_mid_pulse_seen", sb.dmem_we_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_we", sb.dmem_we_o, 0);
    check("rst_mid_addr", sb.dmem_addr_o, 0);
    check("rst_mid_wdata", sb.dmem_wdata_o, 0);
    check("rst_mid_empty", sb.empty_o, 1);
    idle(2);
    rst_n = 1'b1;
    idle(5);
    check("rst_after_empty", sb.empty_o, 1);
    check("final_q", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- In-order FIFO of executed stores, directly downstream of the ex_unit memory-access path.
- Captures the store write enable, address and data produced by mem-access execution.
- Holds each store speculatively until the ROB retires it, then drains committed stores one per cycle to data memory.
- Provides store-to-load forwarding for the load path.
- On a pipeline kill, flushes uncommitted stores and keeps committed ones.

Parameters:
- DEPTH, 4: number of entries; must be a power of two, at least 2.
- ADDR_LEN, 32: address width; matches codebase `ADDR_LEN.
- DATA_LEN, 32: data width; matches codebase `DATA_LEN.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset; one clock; reset is asynchronous and active-low.
- st_we_i  in  1  executed store is valid this cycle (from mem_access_store_buffer_mem_we).
- st_addr_i  in  ADDR_LEN  store byte address (word-aligned).
- st_data_i  in  DATA_LEN  store data.
- com_store_num_i  in  2  stores retired by the ROB this cycle (0..2).
- kill_i  in  1  pipeline flush; drop all uncommitted entries.
- load_busy_i  in  1  load is using the dmem port this cycle; drain is suppressed.
- ld_addr_i  in  ADDR_LEN  load address for forwarding lookup.
- fwd_hit_o  out  1  a buffered store matches ld_addr_i.
- fwd_data_o  out  DATA_LEN  data of the youngest matching store.
- full_o  out  1  all DEPTH entries occupied; upstream must stall store issue.
- empty_o  out  1  no entries.
- dmem_we_o  out  1  drain write strobe.
- dmem_addr_o  out  ADDR_LEN  drain address.
- dmem_wdata_o  out  DATA_LEN  drain data.

Behaviour:
- State:
  - entry arrays addr[DEPTH] and data[DEPTH];
  - head_ptr (oldest entry) and tail_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH;
  - count and com_count, each log2(DEPTH)+1 bits.
  - Invariant: com_count <= count <= DEPTH. Committed entries are the oldest com_count entries from head_ptr.
- Reset (asynchronous, reset_i=0):
  - pointers and counts cleared;
  - full_o=0, empty_o=1, fwd_hit_o=0, fwd_data_o=0, dmem_we_o=0, dmem_addr_o=0, dmem_wdata_o=0.
- Enqueue: when st_we_i && !full_o && !kill_i, write the entry at tail_ptr at the clock edge, then tail_ptr+1 and count+1.
  - st_we_i while full_o: ignored; flagged by a simulation assertion.
- Commit: com_count += min(com_store_num_i, count - com_count).
  - A request that exceeds the uncommitted count is clamped and asserted.
  - An entry enqueued in the same cycle is not committable until the next cycle.
- Drain decision: drain is taken in a cycle when com_count != 0 && !load_busy_i.
- Drain outputs (registered): the drain fires on the clock edge that follows that cycle.
  - Register inputs: dmem_we_o <= drain decision; dmem_addr_o/dmem_wdata_o <= entry[head_ptr].
  - Effects at that edge: head_ptr+1, count-1 and com_count-1.
  - Result: the write strobe is visible one cycle after the decision, latency 1.
  - Addr/data outputs hold their last value when dmem_we_o=0.
- Same-cycle updates: enqueue, commit and drain all apply in one edge.
  - count_next = count + enq - drain.
  - com_count_next = com_count + commit - drain.
- Kill:
  - commit is applied first;
  - the uncommitted remainder is then discarded: tail_ptr = head_ptr + com_count_next, count_next = com_count_next;
  - a same-cycle st_we_i is dropped;
  - a drain in the same cycle still proceeds.
- Forwarding (combinational over valid entries, committed or not):
  - compare addr[ADDR_LEN-1:2] with ld_addr_i[ADDR_LEN-1:2];
  - the youngest match (closest to tail) wins;
  - the same-cycle st_we_i is not visible to forwarding;
  - no match: fwd_hit_o=0, fwd_data_o=0.
- Only full-word stores are handled.
- full_o = (count==DEPTH); empty_o = (count==0). Both are derived from registered state.

Optional Feature:
- STORE_BUFFER_FWD_EN defined: forwarding as above.
- Undefined:
  - fwd_data_o tied to 0;
  - fwd_hit_o asserts on any address match and means "conflict". The load path must retry until the matching store has drained.
  - No data mux is synthesised.

Decomposition:
- Shared package/header (consts): ADDR_LEN, DATA_LEN, and an SB_PTR_W constant equal to log2(DEPTH).
- One sub-module, store_buffer_fwd_match: priority search of the youngest matching entry, given head_ptr, count, the entry addresses and ld_addr_i. It is instantiated only under STORE_BUFFER_FWD_EN; otherwise a plain match-OR is used.

Test Plan:
- Fill to full, then commit, then drain:
  - enqueue 4 stores to 0x100,0x104,0x108,0x10C with data 1..4 -> full_o=1 and a 5th st_we_i is ignored;
  - com_store_num_i=2 for two cycles -> dmem_we_o pulses 4 cycles carrying 0x100/1 .. 0x10C/4 in order, then empty_o=1.
- Kill keeps committed entries: enqueue 3 stores, commit 1, then assert kill_i -> exactly one drain (the first store) and empty_o afterwards; a st_we_i in the kill cycle is not captured.
- Forwarding:
  - store 0x200/0xAA then 0x200/0xBB (uncommitted);
  - ld_addr_i=0x200 -> fwd_hit_o=1, fwd_data_o=0xBB;
  - ld_addr_i=0x204 -> fwd_hit_o=0.
  - Without STORE_BUFFER_FWD_EN -> fwd_hit_o=1, fwd_data_o=0.
- load_busy_i held for 3 cycles with 2 committed entries -> no dmem_we_o during those cycles; drains resume afterwards in order.
- Wrap-around with simultaneous events: enqueue+commit+drain every cycle for 10 stores -> pointers wrap, count stays constant, all 10 reach dmem in order.
- Reset mid-drain: assert reset_i low asynchronously during a dmem_we_o pulse -> all outputs clear immediately, empty_o=1, and no drain after release.
